// File: rtl/pc_fetch.sv
// pc_fetch -- instruction fetch sequencer.
//
// Walks a program counter through a synchronous instruction memory with a
// three-state handshake (FETCH -> WAIT -> VALID) and presents each fetched
// 16-bit word to the downstream code parser until the parser accepts it.
// Optional halt detection is compiled in with the macro PC_FETCH_HALT_EN:
// accepting the word 16'hFFFF then parks the fetcher in a HALT state.
//
// Parameters
//   PC_WIDTH  width of the program counter and the memory address
//   RESET_PC  program counter value loaded by reset
//
// Ports
//   clk_i                       clock, all state on the rising edge
//   rst_i                       synchronous active-high reset
//   mem_en_o                    instruction-memory read enable
//   mem_addr_o                  instruction-memory read address
//   mem_rdata_i                 read data, valid the cycle after mem_en_o
//   redirect_valid_i            one-cycle request to restart at redirect_pc_i
//   redirect_pc_i               restart address
//   code_o                      presented instruction word
//   fetch_pc_o                  address code_o was fetched from
//   pc_fetch_done_o             code_o / fetch_pc_o valid
//   code_paser_back_pressure_i  parser cannot accept this cycle
//   instr_count_o               instructions accepted since reset (wraps)
module pc_fetch #(
    parameter int unsigned         PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                mem_en_o,
    output logic [PC_WIDTH-1:0] mem_addr_o,
    input  logic [15:0]         mem_rdata_i,
    input  logic                redirect_valid_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    output logic [15:0]         code_o,
    output logic [PC_WIDTH-1:0] fetch_pc_o,
    output logic                pc_fetch_done_o,
    input  logic                code_paser_back_pressure_i,
    output logic [15:0]         instr_count_o
);

`ifdef PC_FETCH_HALT_EN
    typedef enum logic [1:0] {StFetch, StWait, StValid, StHalt} state_e;
`else
    typedef enum logic [1:0] {StFetch, StWait, StValid} state_e;
`endif

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         code_q, code_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [15:0]         count_q, count_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        code_d     = code_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;

        unique case (state_q)
            StFetch: state_d = StWait;
            StWait: begin
                // A redirect in this cycle drops the in-flight word.
                if (!redirect_valid_i) begin
                    code_d     = mem_rdata_i;
                    fetch_pc_d = pc_q;
                end
                state_d = StValid;
            end
            StValid: begin
                if (!code_paser_back_pressure_i) begin
                    pc_d    = pc_q + PC_WIDTH'(1);
                    count_d = count_q + 16'd1;
                    state_d = StFetch;
`ifdef PC_FETCH_HALT_EN
                    if (code_q == 16'hFFFF) state_d = StHalt;
`endif
                end
            end
`ifdef PC_FETCH_HALT_EN
            StHalt: state_d = StHalt;
`endif
            default: state_d = StFetch;
        endcase

        // Redirect overrides the next pc even when a transfer also happens;
        // the transfer itself still counts.
        if (redirect_valid_i) begin
            pc_d    = redirect_pc_i;
            state_d = StFetch;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            code_q     <= '0;
            fetch_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            code_q     <= code_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
        end
    end

    // Pure state decodes: mutually exclusive by construction.
    assign mem_en_o        = (state_q == StFetch);
    assign pc_fetch_done_o = (state_q == StValid);
    assign mem_addr_o      = pc_q;
    assign code_o          = code_q;
    assign fetch_pc_o      = fetch_pc_q;
    assign instr_count_o   = count_q;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        redir;
    logic [7:0]  redir_pc;
    logic [15:0] code;
    logic [7:0]  fetch_pc;
    logic        done;
    logic        bp;
    logic [15:0] count;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mem [256];

    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the enable.
    always_ff @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    pc_fetch #(
        .PC_WIDTH (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk_i                      (clk),
        .rst_i                      (rst),
        .mem_en_o                   (mem_en),
        .mem_addr_o                 (mem_addr),
        .mem_rdata_i                (mem_rdata),
        .redirect_valid_i           (redir),
        .redirect_pc_i              (redir_pc),
        .code_o                     (code),
        .fetch_pc_o                 (fetch_pc),
        .pc_fetch_done_o            (done),
        .code_paser_back_pressure_i (bp),
        .instr_count_o              (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [15:0] exp_code [3];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]     = 16'h0002;
        mem[1]     = 16'h1234;
        mem[2]     = 16'h5678;
        mem[3]     = 16'hFFFF;
        mem[4]     = 16'h9999;
        mem[5]     = 16'h5555;
        mem[8'h40] = 16'h4040;
        mem[8'hFF] = 16'hAAAA;
        exp_code[0] = 16'h0002;
        exp_code[1] = 16'h1234;
        exp_code[2] = 16'h5678;

        rst = 1'b1; bp = 1'b0; redir = 1'b0; redir_pc = 8'h00;
        cyc(); cyc();
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd1);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'h00);
        chk("rst_count", {16'd0, count}, 32'd0);
        chk("rst_code", {16'd0, code}, 32'd0);
        chk("rst_fetch_pc", {24'd0, fetch_pc}, 32'd0);

        // Three back-to-back instructions, one every three cycles.
        rst = 1'b0;
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("seq_done_c%0d", c), {31'd0, done}, {31'd0, (c % 3) == 2});
            chk($sformatf("seq_mem_en_c%0d", c), {31'd0, mem_en}, {31'd0, (c % 3) == 0});
            if ((c % 3) == 2) begin
                chk($sformatf("seq_code_c%0d", c), {16'd0, code}, {16'd0, exp_code[c/3]});
                chk($sformatf("seq_fpc_c%0d", c), {24'd0, fetch_pc}, c / 3);
            end
            cyc();
        end
        chk("seq_count", {16'd0, count}, 32'd3);
        chk("seq_next_addr", {24'd0, mem_addr}, 32'd3);

        // Back pressure held four cycles while 1234 is presented.
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int c = 0; c < 5; c++) cyc();
        chk("bp_pre_count", {16'd0, count}, 32'd1);
        bp = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) bp = 1'b0;
            chk($sformatf("bp_done_%0d", c), {31'd0, done}, 32'd1);
            chk($sformatf("bp_code_%0d", c), {16'd0, code}, 32'h1234);
            chk($sformatf("bp_fpc_%0d", c), {24'd0, fetch_pc}, 32'd1);
            chk($sformatf("bp_mem_en_%0d", c), {31'd0, mem_en}, 32'd0);
            cyc();
        end
        chk("bp_count", {16'd0, count}, 32'd2);
        chk("bp_next_addr", {24'd0, mem_addr}, 32'd2);

        // Reset while VALID under back pressure abandons the word.
        cyc(); cyc();
        chk("rstv_valid", {31'd0, done}, 32'd1);
        bp = 1'b1; cyc();
        rst = 1'b1; cyc();
        chk("rstv_done", {31'd0, done}, 32'd0);
        chk("rstv_addr", {24'd0, mem_addr}, 32'h00);
        chk("rstv_count", {16'd0, count}, 32'd0);
        chk("rstv_mem_en", {31'd0, mem_en}, 32'd1);

        // Redirect to 5, then redirect to 40 during the WAIT of address 5.
        rst = 1'b0; bp = 1'b0; redir = 1'b1; redir_pc = 8'h05; cyc();
        redir = 1'b0;
        chk("rd5_addr", {24'd0, mem_addr}, 32'h05);
        cyc();
        chk("rd5_wait_mem_en", {31'd0, mem_en}, 32'd0);
        redir = 1'b1; redir_pc = 8'h40; cyc();
        redir = 1'b0;
        chk("rd40_done0", {31'd0, done}, 32'd0);
        chk("rd40_addr", {24'd0, mem_addr}, 32'h40);
        cyc();
        chk("rd40_done1", {31'd0, done}, 32'd0);
        cyc();
        chk("rd40_done2", {31'd0, done}, 32'd1);
        chk("rd40_fpc", {24'd0, fetch_pc}, 32'h40);
        chk("rd40_code", {16'd0, code}, 32'h4040);

        // Redirect coinciding with a transfer, then pc wrap FF -> 00.
        mem[0] = 16'hBBBB;
        redir = 1'b1; redir_pc = 8'hFF; cyc();
        redir = 1'b0;
        chk("rdx_count", {16'd0, count}, 32'd1);
        chk("rdx_addr", {24'd0, mem_addr}, 32'hFF);
        cyc(); cyc();
        chk("wrap_done_ff", {31'd0, done}, 32'd1);
        chk("wrap_code_ff", {16'd0, code}, 32'hAAAA);
        chk("wrap_fpc_ff", {24'd0, fetch_pc}, 32'hFF);
        cyc();
        chk("wrap_addr", {24'd0, mem_addr}, 32'h00);
        cyc(); cyc();
        chk("wrap_code_00", {16'd0, code}, 32'hBBBB);
        chk("wrap_fpc_00", {24'd0, fetch_pc}, 32'h00);
        cyc();
        chk("wrap_count", {16'd0, count}, 32'd3);

        // Word FFFF at address 3.
        rst = 1'b1; cyc(); rst = 1'b0;
        redir = 1'b1; redir_pc = 8'h03; cyc();
        redir = 1'b0; cyc(); cyc();
        chk("ff_code", {16'd0, code}, 32'hFFFF);
        chk("ff_done", {31'd0, done}, 32'd1);
        cyc();
`ifdef PC_FETCH_HALT_EN
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("halt_mem_en_%0d", c), {31'd0, mem_en}, 32'd0);
            chk($sformatf("halt_done_%0d", c), {31'd0, done}, 32'd0);
            cyc();
        end
        chk("halt_pc", {24'd0, mem_addr}, 32'h04);
        redir = 1'b1; redir_pc = 8'h00; cyc();
        redir = 1'b0;
        chk("halt_resume_en", {31'd0, mem_en}, 32'd1);
        chk("halt_resume_addr", {24'd0, mem_addr}, 32'h00);
        cyc(); cyc();
        chk("halt_resume_code", {16'd0, code}, 32'hBBBB);
`else
        chk("noh_mem_en", {31'd0, mem_en}, 32'd1);
        chk("noh_addr", {24'd0, mem_addr}, 32'h04);
        cyc(); cyc();
        chk("noh_code", {16'd0, code}, 32'h9999);
        chk("noh_fpc", {24'd0, fetch_pc}, 32'h04);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
